// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Receives a program as a byte stream (16-bit little-endian word count N,
//   then N*4 data bytes), assembles little-endian 32-bit words and writes
//   them into the core's instruction memory. The core is held in reset until
//   the load completes.
//
// Ports:
//   clock      system clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   byte on in_data is valid
//   in_data    stream byte
//   in_ready   loader accepts a byte this cycle
//   mem_we     instruction-memory write strobe, one cycle per word
//   mem_addr   word address of the current write
//   mem_wdata  assembled instruction word
//   core_rst   reset to the core; high until the load completes
//   done       load finished, core running
//   error      load aborted; core held in reset
//
// Optional feature (macro BOOT_CHECKSUM_EN):
//   One trailing byte after the last word must equal the XOR of all data
//   bytes (0x00 when N=0). Match -> RUN, mismatch -> ERR.

module imem_boot_loader #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_rst,
  output logic                  done,
  output logic                  error
);

  localparam logic [2:0] HDR_LO = 3'd0;
  localparam logic [2:0] HDR_HI = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] RUN    = 3'd4;
  localparam logic [2:0] ERR    = 3'd5;
`ifdef BOOT_CHECKSUM_EN
  localparam logic [2:0] CHK    = 3'd6;
  // State entered once all words are written (or N=0)
  localparam logic [2:0] FINAL  = CHK;
`else
  localparam logic [2:0] FINAL  = RUN;
`endif

  // N may equal the capacity, so the comparison needs one extra bit
  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

  logic [2:0]            state_q,     state_d;
  logic [15:0]           count_q,     count_d;
  logic [1:0]            byte_idx_q,  byte_idx_d;
  // One extra bit so the index can reach the capacity without wrapping
  logic [ADDR_WIDTH:0]   word_idx_q,  word_idx_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]            csum_q,      csum_d;
`endif

  logic        accept;
  logic [15:0] n_full;

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      HDR_LO, HDR_HI, DATA: in_ready = 1'b1;
`ifdef BOOT_CHECKSUM_EN
      CHK:                  in_ready = 1'b1;
`endif
      default:              in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid & in_ready;
  assign n_full = {in_data, count_q[7:0]};

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    byte_idx_d  = byte_idx_q;
    word_idx_d  = word_idx_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef BOOT_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      HDR_LO: begin
        if (accept) begin
          count_d[7:0] = in_data;
          state_d      = HDR_HI;
        end
      end
      HDR_HI: begin
        if (accept) begin
          count_d[15:8] = in_data;
          if (n_full == 16'd0) begin
            state_d = FINAL;
          end else if ({1'b0, n_full} > CAPACITY) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          mem_wdata_d[{byte_idx_q, 3'b000} +: 8] = in_data;
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          if (byte_idx_q == 2'd3) begin
            // Latch the address here so it stays put after the index advances
            mem_addr_d = word_idx_q[ADDR_WIDTH-1:0];
            state_d    = WRITE;
          end
        end
      end
      WRITE: begin
        word_idx_d = word_idx_q + 1'b1;
        if ((17'(word_idx_q) + 17'd1) == {1'b0, count_q}) begin
          state_d = FINAL;
        end else begin
          state_d = DATA;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          state_d = (in_data == csum_q) ? RUN : ERR;
        end
      end
`endif
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= HDR_LO;
      count_q     <= '0;
      byte_idx_q  <= '0;
      word_idx_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      byte_idx_q  <= byte_idx_d;
      word_idx_q  <= word_idx_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign mem_we    = (state_q == WRITE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign core_rst  = (state_q != RUN);
  assign done      = (state_q == RUN);
  assign error     = (state_q == ERR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: stimulus pushes expected memory writes
// into a queue, a monitor pops and compares on every mem_we pulse.
module tb_imem_boot_loader;

  localparam int unsigned AW = 8;
  localparam int unsigned CAP = 1 << AW;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clock = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_rst;
  logic          done;
  logic          error;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
    .clock     (clock),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_rst  (core_rst),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (!rst && mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%02h data 0x%08h expected no write", mem_addr, mem_wdata);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("mem_addr", 32'(mem_addr), 32'(w.addr));
        check("mem_wdata", mem_wdata, w.data);
      end
      check("we_while_ready", 32'(in_ready), 32'd0);
    end
  end

  // Reference model: derives expected writes and outcome from the stream bytes
  task automatic model(input bq_t s, output int unsigned used, output bit exp_err,
                       output int unsigned lat);
    int unsigned n;
    logic [7:0]  x;
    logic [31:0] d;
    n = 32'(s[0]) + 256 * 32'(s[1]);
    x = 8'h00;
    if (n > CAP) begin
      used = 2; exp_err = 1'b1; lat = 1;
      return;
    end
    for (int unsigned w = 0; w < n; w++) begin
      d = 32'(s[2+4*w]) | (32'(s[3+4*w]) << 8) | (32'(s[4+4*w]) << 16) | (32'(s[5+4*w]) << 24);
      x = x ^ s[2+4*w] ^ s[3+4*w] ^ s[4+4*w] ^ s[5+4*w];
      exp_q.push_back(wr_t'{addr: AW'(w), data: d});
    end
    used = 2 + 4 * n;
    exp_err = 1'b0;
    lat = (n == 0) ? 1 : 2;
`ifdef BOOT_CHECKSUM_EN
    used = used + 1;
    exp_err = (s[used-1] != x);
    lat = 1;
`endif
  endtask

  task automatic append_sum(inout bq_t s);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 2; i < s.size(); i++) x = x ^ s[i];
    s.push_back(x);
  endtask

  task automatic gen(input int unsigned n, input bit bad, output bq_t s);
    logic [7:0] b;
    logic [7:0] x;
    logic [15:0] n16;
    n16 = n[15:0];
    x = 8'h00;
    s = {};
    s.push_back(n16[7:0]);
    s.push_back(n16[15:8]);
    if (n <= CAP) begin
      for (int unsigned i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        x = x ^ b;
        s.push_back(b);
      end
    end
    s.push_back(bad ? (x ^ 8'(1 + $urandom_range(0, 254))) : x);
    s.push_back(8'($urandom));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    for (int guard = 0; guard < 40; guard++) begin
      @(negedge clock);
      if (stall && ($urandom_range(0, 1) == 1)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(posedge clock);
      end else begin
        in_valid = 1'b1;
        in_data  = b;
        if (in_ready) begin
          @(posedge clock);
          return;
        end
        @(posedge clock);
      end
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout: got no acceptance of 0x%02h expected acceptance", b);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_core_rst"}, 32'(core_rst), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  task automatic apply_reset(input string tag);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check_reset_outputs(tag);
    @(negedge clock);
    rst = 1'b0;
  endtask

  task automatic run_stream(input string tag, input bq_t s, input bit stall);
    int unsigned used;
    int unsigned lat;
    bit          exp_err;
    model(s, used, exp_err, lat);
    for (int unsigned i = 0; i < used; i++) send_byte(s[i], stall);
    for (int unsigned c = 1; c <= lat; c++) begin
      @(negedge clock);
      if (c < lat) check({tag, "_done_early"}, 32'(done), 32'd0);
    end
    in_valid = 1'b0;
    check({tag, "_done"}, 32'(done), 32'(!exp_err));
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    check({tag, "_core_rst"}, 32'(core_rst), 32'(exp_err));
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    for (int unsigned i = used; i < s.size() + 2; i++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = (i < s.size()) ? s[i] : 8'($urandom);
      check({tag, "_ready_after_end"}, 32'(in_ready), 32'd0);
      @(posedge clock);
    end
    in_valid = 1'b0;
    @(negedge clock);
    check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation time limit expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t s;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #1;
    check_reset_outputs("por");
    repeat (2) @(negedge clock);
    rst = 1'b0;

    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    append_sum(s);
    run_stream("two_words", s, 1'b0);
    apply_reset("rst1");
    run_stream("two_words_stall", s, 1'b1);

    apply_reset("rst2");
    s = '{8'h00, 8'h00, 8'h00};
    run_stream("empty", s, 1'b0);

    apply_reset("rst3");
    s = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    run_stream("too_big", s, 1'b0);

    // Reset after two bytes of the second word
    apply_reset("rst4");
    exp_q.push_back(wr_t'{addr: '0, data: 32'h04030201});
    s = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB};
    for (int i = 0; i < s.size(); i++) send_byte(s[i], 1'b0);
    apply_reset("midload");
    check("midload_writes", 32'(exp_q.size()), 32'd0);
    s = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    append_sum(s);
    run_stream("deadbeef", s, 1'b0);

    apply_reset("rst5");
    s = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    run_stream("sum_ok", s, 1'b0);
    apply_reset("rst6");
    s = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    run_stream("sum_bad", s, 1'b0);

    apply_reset("rst7");
    gen(CAP, 1'b0, s);
    run_stream("full_capacity", s, 1'b0);

    for (int it = 0; it < 10; it++) begin
      int unsigned n;
      apply_reset("rst_rand");
      n = (it == 3) ? 32'h1234 : $urandom_range(0, 6);
      gen(n, ($urandom_range(0, 3) == 0), s);
      run_stream("random", s, ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
